button_event: RTL and testbench

//  Classifies the debounced button level from the chattering filter into single-cycle

---
 rtl/button_event.sv | 121 ++++++++++++
 tb/tb_button_event.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Classifies a debounced, active-low button level into single-cycle SHORT,
// DOUBLE and LONG press pulses, a HOLD level and a wrapping event counter.
module button_event #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 15_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       short_p,
  output logic       double_p,
  output logic       long_p,
  output logic       holding,
  output logic [7:0] event_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_q;
  logic             short_q;
  logic             double_q;
  logic             long_q;
  logic             hold_q;
  logic [7:0]       evt_q;
  logic             press;

  // btn_q resets to "pressed" so a button held through reset must be released first.
  assign press = btn_q & ~btn_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      btn_q    <= btn_in;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= PRESS1;
            cnt_q   <= '0;
          end
        end
        // Long qualification is tested before release so a release on the
        // final counted cycle still yields a long press.
        PRESS1, PRESS2: begin
          if (cnt_q == LONG_LAST) begin
            state_q <= LONG_HOLD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
            hold_q  <= 1'b1;
            evt_q   <= evt_q + 8'd1;
          end else if (btn_in) begin
            cnt_q <= '0;
            if (state_q == PRESS1) begin
              state_q <= GAP;
            end else begin
              state_q  <= IDLE;
              double_q <= 1'b1;
              evt_q    <= evt_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (press) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b1;
            evt_q   <= evt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LONG_HOLD: begin
          if (btn_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign short_p   = short_q;
  assign double_p  = double_q;
  assign long_p    = long_q;
  assign holding   = hold_q;
  assign event_cnt = evt_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: scenario tasks plus a random run, checked each cycle
// against a timestamp-based reference model of the press classification rules.
module tb_button_event;
  localparam int L = 10;
  localparam int G = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       short_p, double_p, long_p, holding;
  logic [7:0] event_cnt;

  int total = 0;
  int bad   = 0;

  button_event #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .short_p(short_p), .double_p(double_p), .long_p(long_p),
    .holding(holding), .event_cnt(event_cnt)
  );

  always #10 clk = ~clk;

  // Reference model: remembers when the current press/release began and how many
  // clicks are pending; classification follows from elapsed edge counts.
  bit         m_prev, m_down, m_held, m_short, m_double, m_long;
  int         m_clicks, m_tpress, m_trel, m_n;
  logic [7:0] m_cnt;
  bit         wave[$];

  function automatic void model_reset();
    m_prev = 1'b0; m_down = 1'b0; m_held = 1'b0;
    m_short = 1'b0; m_double = 1'b0; m_long = 1'b0;
    m_clicks = 0; m_tpress = 0; m_trel = 0; m_n = 0; m_cnt = 8'd0;
  endfunction

  function automatic void model_edge(input bit b);
    bit pr;
    pr = m_prev & ~b;
    m_short = 1'b0; m_double = 1'b0; m_long = 1'b0;
    m_n++;
    if (m_held) begin
      if (b) m_held = 1'b0;
    end else if (m_clicks > 0 && m_down) begin
      if (m_n - m_tpress == L) begin
        m_long = 1'b1; m_held = 1'b1; m_down = 1'b0; m_clicks = 0;
      end else if (b) begin
        m_down = 1'b0;
        if (m_clicks == 1) m_trel = m_n;
        else begin m_double = 1'b1; m_clicks = 0; end
      end
    end else if (m_clicks == 1) begin
      if (pr) begin m_down = 1'b1; m_clicks = 2; m_tpress = m_n; end
      else if (m_n - m_trel == G) begin m_short = 1'b1; m_clicks = 0; end
    end else if (pr) begin
      m_clicks = 1; m_down = 1'b1; m_tpress = m_n;
    end
    if (m_short || m_double || m_long) m_cnt = m_cnt + 8'd1;
    m_prev = b;
  endfunction

  function automatic void add(input bit b, input int n);
    for (int k = 0; k < n; k++) wave.push_back(b);
  endfunction

  task automatic step(input bit b);
    @(negedge clk);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
  endtask

  task automatic test_reset();
    int np;
    np = 0;
    #5 rst = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    total++;
    if ({short_p, double_p, long_p, holding, event_cnt} !== 12'h000) begin
      bad++; $display("FAIL reset_vals got=%b want=0", {short_p, double_p, long_p, holding, event_cnt});
    end
    @(negedge clk) rst = 1'b1;
    wave.delete(); add(0, 4); add(1, 20);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL reset_held cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (short_p || double_p || long_p) np++;
    end
    total++;
    if (np != 0 || event_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_held_nopulse got pulses=%0d cnt=%0d want 0/0", np, event_cnt);
    end
  endtask

  task automatic test_short();
    int ns, nx, ts;
    logic [7:0] c0;
    ns = 0; nx = 0; ts = -1; c0 = m_cnt;
    wave.delete(); add(1, 2); add(0, 3); add(1, 12);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL short cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (short_p) begin ns++; ts = i; end
      if (double_p || long_p) nx++;
    end
    total++;
    if (ns != 1 || nx != 0 || ts != 10 || event_cnt !== c0 + 8'd1) begin
      bad++; $display("FAIL short_pulse got n=%0d other=%0d at=%0d cnt=%0d want 1/0/10/%0d", ns, nx, ts, event_cnt, c0 + 8'd1);
    end
  endtask

  task automatic test_double();
    int nd, nx, td;
    logic [7:0] c0;
    nd = 0; nx = 0; td = -1; c0 = m_cnt;
    wave.delete(); add(1, 2); add(0, 3); add(1, 2); add(0, 3); add(1, 10);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL double cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (double_p) begin nd++; td = i; end
      if (short_p || long_p) nx++;
    end
    total++;
    if (nd != 1 || nx != 0 || td != 10 || event_cnt !== c0 + 8'd1) begin
      bad++; $display("FAIL double_pulse got n=%0d other=%0d at=%0d cnt=%0d want 1/0/10/%0d", nd, nx, td, event_cnt, c0 + 8'd1);
    end
  endtask

  task automatic test_long();
    int nl, nx, tl, nh;
    nl = 0; nx = 0; tl = -1; nh = 0;
    wave.delete(); add(1, 2); add(0, 15); add(1, 8);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL long cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (long_p) begin nl++; tl = i; end
      if (short_p || double_p) nx++;
      if (holding) nh++;
    end
    total++;
    if (nl != 1 || nx != 0 || tl != 12 || nh != 5 || holding !== 1'b0) begin
      bad++; $display("FAIL long_pulse got n=%0d other=%0d at=%0d hold=%0d/%b want 1/0/12/5/0", nl, nx, tl, nh, holding);
    end
  endtask

  task automatic test_double_long();
    int nl, nx, tl;
    nl = 0; nx = 0; tl = -1;
    wave.delete(); add(1, 2); add(0, 3); add(1, 2); add(0, 12); add(1, 8);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL dbl_long cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (long_p) begin nl++; tl = i; end
      if (short_p || double_p) nx++;
      if (i == 18) begin
        total++;
        if (holding !== 1'b1) begin bad++; $display("FAIL dbl_long_hold got=%b want=1", holding); end
      end
    end
    total++;
    if (nl != 1 || nx != 0 || tl != 17) begin
      bad++; $display("FAIL dbl_long_pulse got n=%0d other=%0d at=%0d want 1/0/17", nl, nx, tl);
    end
  endtask

  task automatic test_boundaries();
    int nl, nd, ns;
    for (int sc = 0; sc < 3; sc++) begin
      nl = 0; nd = 0; ns = 0;
      wave.delete();
      case (sc)
        0: begin add(1, 2); add(0, L); add(1, 10); end
        1: begin add(1, 2); add(0, 3); add(1, G); add(0, 3); add(1, 10); end
        default: begin add(1, 2); add(0, 3); add(1, G + 1); add(0, 3); add(1, 10); end
      endcase
      foreach (wave[i]) begin
        step(wave[i]);
        total++;
        if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
          bad++; $display("FAIL boundary%0d cyc%0d got=%b want=%b", sc, i,
            {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
        end
        if (long_p) nl++;
        if (double_p) nd++;
        if (short_p) ns++;
      end
      total++;
      if ((sc == 0 && {nl, nd, ns} != {32'd1, 32'd0, 32'd0}) ||
          (sc == 1 && {nl, nd, ns} != {32'd0, 32'd1, 32'd0}) ||
          (sc == 2 && {nl, nd, ns} != {32'd0, 32'd0, 32'd2})) begin
        bad++; $display("FAIL boundary%0d_counts got l=%0d d=%0d s=%0d", sc, nl, nd, ns);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    int ns;
    ns = 0;
    wave.delete(); add(1, 2); add(0, 3); add(1, 2);
    foreach (wave[i]) step(wave[i]);
    #4 rst = 1'b0;
    model_reset();
    #1;
    total++;
    if ({short_p, double_p, long_p, holding, event_cnt} !== 12'h000) begin
      bad++; $display("FAIL midgap_async got=%b want=0", {short_p, double_p, long_p, holding, event_cnt});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({short_p, double_p, long_p, holding, event_cnt} !== 12'h000) begin
      bad++; $display("FAIL midgap_inreset got=%b want=0", {short_p, double_p, long_p, holding, event_cnt});
    end
    @(negedge clk) rst = 1'b1;
    wave.delete(); add(1, 10);
    foreach (wave[i]) begin
      step(wave[i]);
      if (short_p || double_p || long_p) ns++;
    end
    total++;
    if (ns != 0) begin bad++; $display("FAIL midgap_nopulse got=%0d want=0", ns); end
    wave.delete(); add(0, 3); add(1, 10);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL midgap_after cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      if (short_p) ns++;
    end
    total++;
    if (ns != 1 || event_cnt !== 8'd1) begin
      bad++; $display("FAIL midgap_recover got s=%0d cnt=%0d want 1/1", ns, event_cnt);
    end
  endtask

  task automatic test_random();
    bit lvl;
    bit prev_pulse;
    int np;
    lvl = 1'b1; prev_pulse = 1'b0;
    wave.delete();
    for (int s = 0; s < 60; s++) begin
      add(lvl, int'($urandom_range(1, 14)));
      lvl = ~lvl;
    end
    add(1, 16);
    foreach (wave[i]) begin
      step(wave[i]);
      total++;
      if ({short_p, double_p, long_p, holding, event_cnt} !== {m_short, m_double, m_long, m_held, m_cnt}) begin
        bad++; $display("FAIL random cyc%0d got=%b want=%b", i,
          {short_p, double_p, long_p, holding, event_cnt}, {m_short, m_double, m_long, m_held, m_cnt});
      end
      np = int'(short_p) + int'(double_p) + int'(long_p);
      if (np > 1 || (np == 1 && prev_pulse)) begin
        bad++; $display("FAIL random_exclusive cyc%0d got pulses=%0d prev=%b want <=1 and no repeat", i, np, prev_pulse);
      end
      prev_pulse = (np != 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 1'b1;
    model_reset();
    test_reset();
    test_short();
    test_double();
    test_long();
    test_double_long();
    test_boundaries();
    test_reset_mid_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
